// File: rtl/ysyx_23060208_axi_rmaster_if.sv
// Bundle of core request/response and AXI read-channel signals for ysyx_23060208_axi_rmaster.
// The master modport is the read master's view; slave is the core/bus side.
interface ysyx_23060208_axi_rmaster_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [DATA_WIDTH-1:0]     req_addr;
    logic [2:0]                req_size;
    logic [3:0]                req_id;

    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_WIDTH*2-1:0]   resp_data;
    logic                      resp_err;

    logic [DATA_WIDTH-1:0]     master_araddr;
    logic                      master_arvalid;
    logic [3:0]                master_arid;
    logic [7:0]                master_arlen;
    logic [2:0]                master_arsize;
    logic [1:0]                master_arburst;
    logic                      master_arready;

    logic                      master_rvalid;
    logic [DATA_WIDTH*2-1:0]   master_rdata;
    logic [1:0]                master_rresp;
    logic                      master_rlast;
    logic [3:0]                master_rid;
    logic                      master_rready;

    modport master (
        input  req_valid, req_addr, req_size, req_id, resp_ready,
        input  master_arready,
        input  master_rvalid, master_rdata, master_rresp, master_rlast, master_rid,
        output req_ready, resp_valid, resp_data, resp_err,
        output master_araddr, master_arvalid, master_arid, master_arlen, master_arsize,
        output master_arburst, master_rready
    );

    modport slave (
        output req_valid, req_addr, req_size, req_id, resp_ready,
        output master_arready,
        output master_rvalid, master_rdata, master_rresp, master_rlast, master_rid,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  master_araddr, master_arvalid, master_arid, master_arlen, master_arsize,
        input  master_arburst, master_rready
    );
endinterface

// File: rtl/ysyx_23060208_axi_rmaster.sv
// Single-outstanding AXI read master: one request, one single-beat AR, one response.
// Define YSYX_23060208_RD_TIMEOUT_EN to abort the R wait after TIMEOUT cycles.
module ysyx_23060208_axi_rmaster #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic                           clock,
    input logic                           reset,
    ysyx_23060208_axi_rmaster_if.master   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]              state_q;
    logic [DATA_WIDTH-1:0]   araddr_q;
    logic [3:0]              arid_q;
    logic [2:0]              arsize_q;
    logic                    arvalid_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH*2-1:0] resp_data_q;
    logic                    resp_err_q;
    logic                    sticky_err_q;

    logic beat;
    logic id_match;
    logic final_beat;

    assign beat       = (state_q == DATA) && bus.master_rvalid;
    assign id_match   = (bus.master_rid == arid_q);
    assign final_beat = beat && id_match && bus.master_rlast;

`ifdef YSYX_23060208_RD_TIMEOUT_EN
    localparam int CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            timed_out;

    assign timed_out = (state_q == DATA) && !final_beat && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == ADDR) begin
            wait_cnt_q <= '0;
        end else if (state_q == DATA) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
        end
    end
`else
    logic timed_out;
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arid_q       <= '0;
            arsize_q     <= '0;
            arvalid_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            sticky_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q      <= ADDR;
                        araddr_q     <= bus.req_addr;
                        arid_q       <= bus.req_id;
                        arsize_q     <= bus.req_size;
                        arvalid_q    <= 1'b1;
                        resp_err_q   <= 1'b0;
                        sticky_err_q <= 1'b0;
                    end
                end
                ADDR: begin
                    if (bus.master_arready) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (final_beat) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= bus.master_rdata;
                        resp_err_q   <= sticky_err_q || (bus.master_rresp != 2'b00);
                    end else if (timed_out) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                    end else if (beat && id_match) begin
                        // Non-last beat of a single-beat burst is a protocol error.
                        sticky_err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.master_rready  = (state_q == DATA);
    assign bus.master_arvalid = arvalid_q;
    assign bus.master_araddr  = araddr_q;
    assign bus.master_arid    = arid_q;
    assign bus.master_arsize  = arsize_q;
    assign bus.master_arlen   = 8'd0;
    assign bus.master_arburst = 2'b01;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_err       = resp_err_q;
endmodule

// File: tb/tb_ysyx_23060208_axi_rmaster.sv
// Directed bench for ysyx_23060208_axi_rmaster; timeout scenario only when
// YSYX_23060208_RD_TIMEOUT_EN is defined.
module tb_ysyx_23060208_axi_rmaster;
    localparam int DW  = 32;
`ifdef YSYX_23060208_RD_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    ysyx_23060208_axi_rmaster_if #(.DATA_WIDTH(DW)) bus ();

    ysyx_23060208_axi_rmaster #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.req_size       = '0;
        bus.req_id         = '0;
        bus.resp_ready     = 1'b0;
        bus.master_arready = 1'b0;
        bus.master_rvalid  = 1'b0;
        bus.master_rdata   = '0;
        bus.master_rresp   = '0;
        bus.master_rlast   = 1'b0;
        bus.master_rid     = '0;
    endtask

    // Present a request for one cycle; returns in the cycle after acceptance.
    task automatic start_req(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_id    = id;
        bus.req_size  = size;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic set_beat(input logic v, input logic [3:0] id, input logic [63:0] d,
                            input logic [1:0] resp, input logic last);
        bus.master_rvalid = v;
        bus.master_rid    = id;
        bus.master_rdata  = d;
        bus.master_rresp  = resp;
        bus.master_rlast  = last;
    endtask

    // Immediate AR/R read; reports observed data/err and acceptance-to-resp latency.
    task automatic run_read(input logic [31:0] addr, input logic [3:0] id, input logic [63:0] d,
                            input logic [1:0] resp, output logic [63:0] obs_d,
                            output logic obs_e, output int lat);
        bus.master_arready = 1'b1;
        set_beat(1'b1, id, d, resp, 1'b1);
        start_req(addr, id, 3'd3);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (bus.resp_valid !== 1'b1) lat = -1;
        obs_d = bus.resp_data;
        obs_e = bus.resp_err;
        bus.master_arready = 1'b0;
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.master_arvalid !== 1'b0 || bus.master_rready !== 1'b0 ||
            bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got rr=%b arv=%b rrdy=%b rv=%b re=%b, want 1 0 0 0 0",
                     bus.req_ready, bus.master_arvalid, bus.master_rready, bus.resp_valid,
                     bus.resp_err);
        end
        tests++;
        if (bus.resp_data !== 64'd0 || bus.master_araddr !== 32'd0 || bus.master_arid !== 4'd0 ||
            bus.master_arsize !== 3'd0 || bus.master_arlen !== 8'd0 ||
            bus.master_arburst !== 2'b01) begin
            fails++;
            $display("FAIL reset_fields: got data=%h addr=%h id=%h size=%h len=%h burst=%b",
                     bus.resp_data, bus.master_araddr, bus.master_arid, bus.master_arsize,
                     bus.master_arlen, bus.master_arburst);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.master_arready = 1'b1;
        set_beat(1'b1, 4'd3, 64'h1122334455667788, 2'b00, 1'b1);
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_req_ready: got %b want 1", bus.req_ready);
        end
        start_req(32'h1000, 4'd3, 3'd3);
        tests++;
        if (bus.master_arvalid !== 1'b1 || bus.master_araddr !== 32'h1000 ||
            bus.master_arid !== 4'd3 || bus.master_arlen !== 8'd0 ||
            bus.master_arsize !== 3'd3 || bus.master_arburst !== 2'b01 ||
            bus.master_rready !== 1'b0 || bus.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_ar: got v=%b a=%h id=%h len=%h sz=%h b=%b rrdy=%b rr=%b",
                     bus.master_arvalid, bus.master_araddr, bus.master_arid, bus.master_arlen,
                     bus.master_arsize, bus.master_arburst, bus.master_rready, bus.req_ready);
        end
        tick();
        tests++;
        if (bus.master_arvalid !== 1'b0 || bus.master_rready !== 1'b1 ||
            bus.resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_data: got arv=%b rrdy=%b rv=%b want 0 1 0",
                     bus.master_arvalid, bus.master_rready, bus.resp_valid);
        end
        tick();
        tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h1122334455667788 ||
            bus.resp_err !== 1'b0 || bus.master_rready !== 1'b0) begin
            fails++;
            $display("FAIL basic_resp: got rv=%b d=%h e=%b rrdy=%b want 1 1122334455667788 0 0",
                     bus.resp_valid, bus.resp_data, bus.resp_err, bus.master_rready);
        end
        bus.master_arready = 1'b0;
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_idle: got rv=%b rr=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_backpressure();
        start_req(32'h2000, 4'd7, 3'd2);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.master_arready = 1'b1;
            tests++;
            if (bus.master_arvalid !== 1'b1 || bus.master_araddr !== 32'h2000 ||
                bus.master_arid !== 4'd7 || bus.master_arsize !== 3'd2) begin
                fails++;
                $display("FAIL bp_ar_stable[%0d]: got v=%b a=%h id=%h sz=%h want 1 2000 7 2",
                         i, bus.master_arvalid, bus.master_araddr, bus.master_arid,
                         bus.master_arsize);
            end
            tick();
        end
        bus.master_arready = 1'b0;
        set_beat(1'b1, 4'd7, 64'hDEADBEEF00000001, 2'b00, 1'b1);
        tick();
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.resp_ready = 1'b1;
            tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hDEADBEEF00000001 ||
                bus.resp_err !== 1'b0) begin
                fails++;
                $display("FAIL bp_resp_stable[%0d]: got rv=%b d=%h e=%b want 1 deadbeef00000001 0",
                         i, bus.resp_valid, bus.resp_data, bus.resp_err);
            end
            tick();
        end
        bus.resp_ready = 1'b0;
        tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_idle: got rv=%b rr=%b want 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_error_resp();
        logic [63:0] d;
        logic        e;
        int          lat;
        run_read(32'h3000, 4'd2, 64'h55, 2'b10, d, e, lat);
        tests++;
        if (e !== 1'b1 || d !== 64'h55 || lat != 3) begin
            fails++;
            $display("FAIL err_slverr: got e=%b d=%h lat=%0d want 1 55 3", e, d, lat);
        end
        // Back-to-back: next request presented in the cycle the FSM returns to IDLE.
        run_read(32'h3008, 4'd2, 64'h66, 2'b00, d, e, lat);
        tests++;
        if (e !== 1'b0 || d !== 64'h66 || lat != 3) begin
            fails++;
            $display("FAIL err_clean_after: got e=%b d=%h lat=%0d want 0 66 3", e, d, lat);
        end
    endtask

    task automatic test_id_mismatch();
        bus.master_arready = 1'b1;
        start_req(32'h4000, 4'd3, 3'd3);
        tick();
        bus.master_arready = 1'b0;
        set_beat(1'b1, 4'd5, 64'h11, 2'b00, 1'b1);
        tests++;
        if (bus.master_rready !== 1'b1) begin
            fails++;
            $display("FAIL idm_rready: got %b want 1", bus.master_rready);
        end
        tick();
        set_beat(1'b1, 4'd3, 64'hAB, 2'b00, 1'b1);
        tests++;
        if (bus.resp_valid !== 1'b0 || bus.master_rready !== 1'b1) begin
            fails++;
            $display("FAIL idm_dropped: got rv=%b rrdy=%b want 0 1",
                     bus.resp_valid, bus.master_rready);
        end
        tick();
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
        tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hAB || bus.resp_err !== 1'b0) begin
            fails++;
            $display("FAIL idm_resp: got rv=%b d=%h e=%b want 1 ab 0",
                     bus.resp_valid, bus.resp_data, bus.resp_err);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_sticky_err();
        bus.master_arready = 1'b1;
        start_req(32'h5000, 4'd9, 3'd3);
        tick();
        bus.master_arready = 1'b0;
        set_beat(1'b1, 4'd9, 64'h77, 2'b00, 1'b0);
        tick();
        set_beat(1'b1, 4'd9, 64'h88, 2'b00, 1'b1);
        tick();
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
        tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h88 || bus.resp_err !== 1'b1) begin
            fails++;
            $display("FAIL sticky_err: got rv=%b d=%h e=%b want 1 88 1",
                     bus.resp_valid, bus.resp_data, bus.resp_err);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.master_arready = 1'b1;
        start_req(32'h6000, 4'd3, 3'd3);
        tick();
        bus.master_arready = 1'b0;
        tests++;
        if (bus.master_rready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: rready got %b want 1", bus.master_rready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (bus.master_rready !== 1'b0 || bus.master_arvalid !== 1'b0 ||
            bus.resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async: got rrdy=%b arv=%b rv=%b want 0 0 0",
                     bus.master_rready, bus.master_arvalid, bus.resp_valid);
        end
        tick();
        reset = 1'b1;
        set_beat(1'b1, 4'd3, 64'h99, 2'b00, 1'b1);
        tick();
        tests++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.master_rready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_after: got rr=%b rv=%b rrdy=%b want 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.master_rready);
        end
        set_beat(1'b0, 4'd0, 64'd0, 2'd0, 1'b0);
    endtask

`ifdef YSYX_23060208_RD_TIMEOUT_EN
    task automatic test_timeout();
        bus.master_arready = 1'b1;
        start_req(32'h7000, 4'd4, 3'd3);
        tick();
        bus.master_arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bus.resp_valid !== 1'b0 || bus.master_rready !== 1'b1) begin
                fails++;
                $display("FAIL tmo_wait[%0d]: got rv=%b rrdy=%b want 0 1",
                         i, bus.resp_valid, bus.master_rready);
            end
            tick();
        end
        tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_data !== 64'd0) begin
            fails++;
            $display("FAIL tmo_resp: got rv=%b e=%b d=%h want 1 1 0",
                     bus.resp_valid, bus.resp_err, bus.resp_data);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_error_resp();
        test_id_mismatch();
        test_sticky_err();
        test_reset_mid();
`ifdef YSYX_23060208_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
